// File: rtl/muldiv_sequencer.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// A shift-add multiplier and a restoring divider share one 2*WIDTH working
// accumulator and retire one bit per cycle. Magnitudes are processed and the
// sign is restored at the end.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {upper, lower} working pair
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sgnq_q, sgnq_d;     // result (product/quotient) sign
  logic               sgnr_q, sgnr_d;     // remainder sign
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, divz_q, divz_d;

  logic               is_signed, is_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_sh, div_trial;
  logic [2*WIDTH-1:0] prod_fix;

  // Absolute value for signed operands; 0x80..0 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // Conditional two's-complement negation; negating zero stays zero.
  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v,
                                            input logic sgn);
    return sgn ? -v : v;
  endfunction

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];

  // One multiply step: add multiplicand to the upper half when the multiplier
  // LSB is set (keeping the carry), then shift the pair right. One restoring
  // divide step: shift remainder/dividend left and trial-subtract the divisor.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial  = div_rem_sh - {1'b0, opnd_q};
    prod_fix   = sgnq_q ? -acc_q : acc_q;
  end

  // Next-state, datapath sequencing and result write-back.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    divz_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = PREP;
        end
      end
      PREP: begin
        sgnq_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        sgnr_d = is_signed & a_q[WIDTH-1];
        if (is_div) begin
          opnd_d = mag(b_q, is_signed);
          acc_d  = {{WIDTH{1'b0}}, mag(a_q, is_signed)};
        end else begin
          opnd_d = mag(a_q, is_signed);
          acc_d  = {{WIDTH{1'b0}}, mag(b_q, is_signed)};
        end
        // Divide-by-zero leaves through FIX so both completions share one exit.
        if (is_div && (b_q == '0)) begin
          dz_d    = 1'b1;
          state_d = FIX;
        end else begin
          dz_d    = 1'b0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (is_div) begin
          if (!div_trial[WIDTH])
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        if (!dz_q) begin
          if (is_div) begin
            lo_d = cneg(acc_q[WIDTH-1:0], sgnq_q);
            hi_d = cneg(acc_q[2*WIDTH-1:WIDTH], sgnr_q);
          end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        done_d  = 1'b1;
        divz_d  = dz_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and working registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = divz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
